// File: rtl/transport_packetizer.sv
// Transport packetizer: assembles control/audio words into fixed-length byte packets,
// queues them in a byte FIFO and streams them out over a valid/ready link.
module transport_packetizer #(
  parameter int PKT_BYTES  = 16,
  parameter int WORD_BYTES = 2,
  parameter int FIFO_PKTS  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       phoneNum,
  input  logic [1:0]                       cmd,
  input  logic [8*WORD_BYTES-1:0]          data,
  input  logic                             flush,
  output logic                             busy,
  output logic [7:0]                       out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [$clog2(FIFO_PKTS+1)-1:0]   pkts_ready,
  output logic [7:0]                       drop_count
);
  localparam int DATA_W    = 8*WORD_BYTES;
  localparam int PAY_BYTES = PKT_BYTES-2;
  localparam int DEPTH     = FIFO_PKTS*PKT_BYTES;
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int UW        = $clog2(DEPTH+1);
  localparam int BW        = $clog2(PKT_BYTES);
  localparam int AW        = $clog2(PAY_BYTES+1);
  localparam int AIW       = (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;
  localparam int RW        = $clog2(FIFO_PKTS+1);

  if (WORD_BYTES < 1 || PKT_BYTES < 3 || FIFO_PKTS < 1 || ((PKT_BYTES-2) % WORD_BYTES) != 0) begin : gParamCheck
    $error("transport_packetizer: illegal PKT_BYTES/WORD_BYTES/FIFO_PKTS combination");
  end

  typedef enum logic [1:0] {IDLE, CTRL_WR, AU_WR, COMMIT} state_t;

  state_t             state;
  logic [BW-1:0]      byteIdx;
  logic [AW-1:0]      asmFill;
  logic [5:0]         seq;
  logic [DATA_W-1:0]  ctrlData, auWord;
  logic [7:0]         ctrlDest, auDest;
  logic [7:0]         asmBuf [PAY_BYTES];
  logic [7:0]         mem [DEPTH];
  logic [PW-1:0]      wrPtr, rdPtr;
  logic [UW-1:0]      used;
  logic [BW-1:0]      outIdx;

  logic               cmdValid, acceptCtrl, acceptAudio, wrEn, wrLast;
  logic               hs, popPkt, advance, loadNext, loadFirst;
  logic [BW-1:0]      payPos;
  logic [DATA_W-1:0]  ctrlShift;
  logic [7:0]         wrByte;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Free space counts bytes not yet handshaked, so the byte held in out_data is never overwritten.
  assign busy        = (state != IDLE) || (used > UW'(DEPTH - PKT_BYTES));
  assign cmdValid    = (cmd == 2'b01) || (cmd == 2'b10);
  assign acceptCtrl  = (state == IDLE) && (cmd == 2'b01) && !busy;
  assign acceptAudio = (state == IDLE) && (cmd == 2'b10) && !busy;
  assign wrEn        = (state == CTRL_WR) || (state == COMMIT);
  assign wrLast      = wrEn && (byteIdx == BW'(PKT_BYTES-1));

  assign hs        = out_valid && out_ready;
  assign popPkt    = hs && out_eop;
  assign advance   = !out_valid || out_ready;
  assign loadNext  = hs && !out_eop;
  assign loadFirst = advance && !loadNext &&
                     (out_valid ? (pkts_ready > RW'(1)) : (pkts_ready != '0));

  assign payPos    = byteIdx - BW'(2);
  assign ctrlShift = ctrlData << {payPos, 3'b000};

  always_comb begin
    wrByte = 8'h00;
    if (byteIdx == '0)
      wrByte = {(state == CTRL_WR) ? 2'b01 : 2'b10, seq};
    else if (byteIdx == BW'(1))
      wrByte = (state == CTRL_WR) ? ctrlDest : auDest;
    else if (state == CTRL_WR) begin
      if (payPos < BW'(WORD_BYTES)) wrByte = ctrlShift[DATA_W-1 -: 8];
    end else if (payPos < BW'(asmFill))
      wrByte = asmBuf[payPos[AIW-1:0]];
  end

  // Input FSM: command accept, audio assembly and packet writes into the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      byteIdx <= '0;
      asmFill <= '0;
      seq     <= '0;
    end else begin
      case (state)
        IDLE: begin
          byteIdx <= '0;
          if (acceptCtrl)
            state <= CTRL_WR;
          else if (acceptAudio)
            state <= AU_WR;
          else if (cmd == 2'b00 && flush && !busy && asmFill != '0)
            state <= COMMIT;
        end
        CTRL_WR, COMMIT: begin
          byteIdx <= byteIdx + 1'b1;
          if (wrLast) begin
            byteIdx <= '0;
            seq     <= seq + 1'b1;
            state   <= IDLE;
            if (state == COMMIT) asmFill <= '0;
          end
        end
        AU_WR: begin
          asmFill <= asmFill + 1'b1;
          byteIdx <= byteIdx + 1'b1;
          if (byteIdx == BW'(WORD_BYTES-1)) begin
            byteIdx <= '0;
            state   <= (asmFill == AW'(PAY_BYTES-1)) ? COMMIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath storage: latched command words, assembly buffer and FIFO bytes
  always_ff @(posedge clk) begin
    if (acceptCtrl) begin
      ctrlData <= data;
      ctrlDest <= phoneNum;
    end
    if (acceptAudio) begin
      auWord <= data;
      if (asmFill == '0) auDest <= phoneNum;
    end else if (state == AU_WR)
      auWord <= auWord << 8;
    if (state == AU_WR) asmBuf[asmFill[AIW-1:0]] <= auWord[DATA_W-1 -: 8];
    if (wrEn) mem[wrPtr] <= wrByte;
  end

  // Output side: FIFO bookkeeping and the registered byte stream
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      used       <= '0;
      pkts_ready <= '0;
      drop_count <= '0;
      outIdx     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
    end else begin
      if (wrEn) wrPtr <= nextPtr(wrPtr);
      used       <= used + UW'(wrEn) - UW'(hs);
      pkts_ready <= pkts_ready + RW'(wrLast) - RW'(popPkt);
      if (cmdValid && busy && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
      if (loadNext || loadFirst) begin
        out_data  <= mem[rdPtr];
        rdPtr     <= nextPtr(rdPtr);
        out_valid <= 1'b1;
        outIdx    <= loadFirst ? '0 : outIdx + 1'b1;
        out_sop   <= loadFirst;
        out_eop   <= loadNext && (outIdx == BW'(PKT_BYTES-2));
      end else if (advance) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_transport_packetizer.sv
// Bench for transport_packetizer: stimulus queues expected packet bytes, and a
// negedge monitor compares every handshaked output byte against that queue.
module tb_transport_packetizer;
  localparam int PAY = 14;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] phoneNum = 8'h00;
  logic [1:0] cmd = 2'b00;
  logic [15:0] data = 16'h0000;
  logic       flush = 1'b0;
  logic       busy;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_sop, out_eop;
  logic [2:0] pkts_ready;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;
  int readyMode = 0;            // 0 ready held high, 1 held low, 2 random
  logic [9:0] expQ[$];          // {sop, eop, byte}
  logic [7:0] pay[$];
  logic [7:0] auBytes[$];
  logic [7:0] auDestM = 8'h00;
  logic [5:0] mseq = 6'd0;

  transport_packetizer dut (
    .clk(clk), .reset(reset), .phoneNum(phoneNum), .cmd(cmd), .data(data), .flush(flush),
    .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .pkts_ready(pkts_ready), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (out_valid && out_ready && !reset) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte: got %02h with no byte expected", out_data);
      end else begin
        logic [9:0] e;
        e = expQ.pop_front();
        check("stream_sop_eop_byte", {22'd0, out_sop, out_eop, out_data}, {22'd0, e});
      end
    end
  end

  task automatic pushPkt(input logic [1:0] typ, input logic [7:0] dest);
    expQ.push_back({2'b10, typ, mseq});
    expQ.push_back({2'b00, dest});
    for (int i = 0; i < PAY; i++)
      expQ.push_back({(i == PAY-1) ? 2'b01 : 2'b00, (i < pay.size()) ? pay[i] : 8'h00});
    mseq++;
  endtask

  task automatic waitNotBusy();
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: busy still %0b after %0d cycles", busy, n);
    end
  endtask

  task automatic sendCmd(input logic [1:0] c, input logic [15:0] d, input logic [7:0] pn, input logic f);
    waitNotBusy();
    cmd = c; data = d; phoneNum = pn; flush = f;
    @(posedge clk); #1;
    cmd = 2'b00; flush = 1'b0;
  endtask

  task automatic sendCtrl(input logic [15:0] d, input logic [7:0] pn, input logic f);
    sendCmd(2'b01, d, pn, f);
    pay.delete();
    pay.push_back(d[15:8]);
    pay.push_back(d[7:0]);
    pushPkt(2'b01, pn);
  endtask

  task automatic sendAudio(input logic [15:0] d, input logic [7:0] pn);
    if (auBytes.size() == 0) auDestM = pn;
    sendCmd(2'b10, d, pn, 1'b0);
    auBytes.push_back(d[15:8]);
    auBytes.push_back(d[7:0]);
    if (auBytes.size() == PAY) begin
      pay = auBytes;
      pushPkt(2'b10, auDestM);
      auBytes.delete();
    end
  endtask

  task automatic doFlush();
    waitNotBusy();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (auBytes.size() != 0) begin
      pay = auBytes;
      pushPkt(2'b10, auDestM);
      auBytes.delete();
    end
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((expQ.size() != 0 || out_valid || pkts_ready != 0) && n < 6000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 6000) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d bytes still expected", name, expQ.size());
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expQ.delete();
    auBytes.delete();
    mseq = 6'd0;
  endtask

  initial begin
    int n, gaps;
    repeat (2) @(posedge clk);
    #1;
    doReset();
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sop_eop", {out_sop, out_eop}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_pkts_ready", pkts_ready, 0);
    check("rst_drop_count", drop_count, 0);

    // Single control packet: 40 07 A5 5A + zeros, timing of busy and first byte
    sendCtrl(16'hA55A, 8'h07, 1'b0);
    countBusy(n);
    check("ctrl_busy_cycles", n, 16);
    check("ctrl_pkts_ready_up", pkts_ready, 1);
    check("ctrl_valid_latency0", out_valid, 0);
    @(posedge clk); #1;
    check("ctrl_first_valid", out_valid, 1);
    check("ctrl_first_sop", out_sop, 1);
    check("ctrl_first_byte", out_data, 8'h40);
    waitIdle("ctrl_drain");
    check("ctrl_pkts_ready_down", pkts_ready, 0);

    // Seven audio words fill a packet: 81 22 00 01 .. 00 07
    for (int i = 1; i <= 6; i++) sendAudio(16'(i), 8'h22);
    sendAudio(16'h0007, 8'h22);
    countBusy(n);
    check("audio_commit_busy", n, 18);

    // Partial audio with flush, then an empty flush
    for (int i = 0; i < 3; i++) sendAudio(16'h1111, 8'h33);
    doFlush();
    countBusy(n);
    check("flush_commit_busy", n, 16);
    doFlush();
    countBusy(n);
    check("empty_flush_busy", n, 0);
    waitIdle("flush_drain");

    // Command beats flush; control overtakes a partial audio packet
    sendAudio(16'hBEEF, 8'h44);
    sendCtrl(16'h0F0F, 8'h45, 1'b1);
    doFlush();
    waitIdle("overtake_drain");

    // Back-pressure: four packets fill the FIFO, further commands are dropped
    doReset();
    readyMode = 1;
    for (int i = 0; i < 4; i++) sendCtrl(16'h1000 + 16'(i), 8'h50 + 8'(i), 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    check("full_busy", busy, 1);
    check("full_pkts_ready", pkts_ready, 4);
    cmd = 2'b01; data = 16'hDEAD;
    @(posedge clk); #1;
    cmd = 2'b00;
    check("drop_count_one", drop_count, 1);
    cmd = 2'b11;
    @(posedge clk); #1;
    cmd = 2'b00;
    check("reserved_not_counted", drop_count, 1);
    cmd = 2'b10;
    repeat (260) begin @(posedge clk); #1; end
    cmd = 2'b00;
    check("drop_count_saturate", drop_count, 255);
    readyMode = 0;
    gaps = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!out_valid) gaps++;
    end
    check("drain_no_gaps", gaps, 0);
    @(negedge clk);
    check("drain_done_valid", out_valid, 0);
    @(posedge clk); #1;
    waitIdle("backpressure_drain");

    // 64 packets under random back-pressure; seq wraps past 63
    readyMode = 2;
    for (int i = 0; i < 64; i++) sendCtrl(16'($urandom), 8'($urandom), 1'b0);
    waitIdle("random_drain");
    readyMode = 0;

    // Reset in the middle of an output packet and of a COMMIT
    readyMode = 1;
    sendCtrl(16'hC0DE, 8'h61, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("mid_pkt_valid", out_valid, 1);
    readyMode = 0;
    repeat (3) begin @(posedge clk); #1; end
    readyMode = 1;
    for (int i = 0; i < 7; i++) sendAudio(16'hA000 + 16'(i), 8'h62);
    repeat (6) begin @(posedge clk); #1; end
    doReset();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_pkts_ready", pkts_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drop_count", drop_count, 0);
    readyMode = 0;
    sendCtrl(16'h1234, 8'h70, 1'b0);
    sendAudio(16'hABCD, 8'h71);
    doFlush();
    waitIdle("post_reset_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/transport_packetizer.md
Name: transport_packetizer

Overview:
- Parametrised successor of the fixed 128-bit transport packetizer. It converts control words (cmd=01) and audio words (cmd=10) into fixed-length byte packets, each carrying a header, a destination and a payload.
- Packets queue in an internal multi-packet ready FIFO and leave over a byte-wide valid/ready link interface with start/end markers.
- Sits between the call-control/audio front end and the link layer.
- Adds four things the previous block did not have: sequence numbering, partial-packet flush, back-pressure, and a drop counter.

Parameters:
- PKT_BYTES, 16, total bytes per packet including the 2-byte header. Must be ≥3.
- WORD_BYTES, 2, bytes per input word; data width is 8*WORD_BYTES. (PKT_BYTES-2) must be a multiple of WORD_BYTES.
- FIFO_PKTS, 4, ready-FIFO capacity in whole packets. Storage is FIFO_PKTS*PKT_BYTES bytes.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- phoneNum, input, 8, destination number; sampled at command accept.
- cmd, input, 2: 00 idle, 01 control, 10 audio, 11 reserved (ignored, not counted).
- data, input, 8*WORD_BYTES, word to send; MSB byte is sent first.
- flush, input, 1, pulse: pad and commit a partial audio packet.
- busy, output, 1, high when a command would not be accepted.
- out_data, output, 8, packet byte.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, link accepts the byte when out_valid && out_ready.
- out_sop, output, 1, marks byte 0 of a packet (qualified by out_valid).
- out_eop, output, 1, marks byte PKT_BYTES-1 (qualified by out_valid).
- pkts_ready, output, $clog2(FIFO_PKTS+1), number of complete packets in the FIFO and not yet fully sent.
- drop_count, output, 8, saturating count of cmd 01/10 presented while busy.

Behaviour:
- Reset (synchronous):
  - Clears state to IDLE, FIFO pointers, the assembly buffer word count, seq, pkts_ready and drop_count.
  - Outputs: busy=0, out_valid=0, out_sop=0, out_eop=0, out_data=0.
  - Reset during any state discards the partial packet and any in-flight output packet.
- Packet format:
  - Byte0 = {type[1:0], seq[5:0]}, type 01 control, 10 audio.
  - Byte1 = phoneNum latched for that packet.
  - Bytes 2..PKT_BYTES-1 = payload.
  - Control payload: one word, MSB first, then zero padding.
  - Audio payload: (PKT_BYTES-2)/WORD_BYTES words, in arrival order, MSB first.
- seq: 6-bit counter shared by both types. It increments once per committed packet and wraps 63→0.
- busy = (state != IDLE) || (free FIFO bytes < PKT_BYTES).
- Accept rule: cmd 01/10 is accepted only in a cycle with busy=0. Presented while busy=1 it is dropped and drop_count increments, saturating at 255. Upstream must hold or retry.
- Input FSM states:
  - IDLE
    - cmd=01 accepted at cycle T → CTRL_WR.
    - cmd=10 accepted → AU_WR. If the assembly buffer is empty, phoneNum is latched as the audio destination.
    - flush with cmd=00, busy=0 and assembly word count>0 → COMMIT with zero padding.
    - flush with word count=0 → no-op.
    - cmd≠00 in the same cycle as flush: cmd wins and flush is ignored.
  - CTRL_WR
    - Writes the PKT_BYTES bytes of a control packet into the FIFO, one per cycle, during T+1..T+PKT_BYTES.
    - Then → IDLE; busy falls at T+PKT_BYTES+1.
    - An in-progress audio assembly is untouched. Control packets overtake partial audio.
  - AU_WR
    - Writes WORD_BYTES bytes into the assembly buffer, T+1..T+WORD_BYTES.
    - If the packet is now full → COMMIT, else → IDLE.
  - COMMIT
    - Copies header, destination and the assembly buffer (zero-padded) into the FIFO, 1 byte per cycle for PKT_BYTES cycles.
    - Clears the word count, then → IDLE.
- pkts_ready:
  - Increments in the cycle the last byte of a packet is written.
  - Decrements on the out_eop handshake.
  - Simultaneous increment and decrement → unchanged.
- Output side (independent of the input FSM; runs concurrently):
  - Starts only when pkts_ready>0.
  - out_data/out_valid are registered. With the FIFO previously empty, the first byte is valid 2 cycles after the last byte write.
  - Bytes advance only on handshake. out_valid stays high across the packet while bytes remain; stalls hold out_data stable.
  - Back-to-back packets have no gap when pkts_ready>0.
- FIFO full: busy holds off new commands. A write never overflows and a read never underflows.
- Parameter violations are caught by an elaboration-time check.

Test Plan:
- Defaults; reset, then cmd=01, data=16'hA55A, phoneNum=8'h07 accepted at T → busy high T+1..T+16; stream 40 07 A5 5A + 12×00; out_sop on byte0, out_eop on byte15; pkts_ready 1→0.
- Seven cmd=10 words 16'h0001..16'h0007 with phoneNum=8'h22, each sent when busy=0 → one packet 81 22 00 01 … 00 07 (seq=1); busy covers the 16 COMMIT cycles after word 7.
- Three audio words 16'h1111, then flush → packet 80|seq, dest, 11 11 ×3 + 8×00; flush with an empty buffer → no packet, seq unchanged.
- out_ready=0 with 4 control commands issued → busy stays high after the 4th, a 5th cmd is dropped, drop_count=1, pkts_ready=4; release out_ready → 64 bytes drain with no gaps, seq 0..3.
- 64 control packets → header seq wraps 63→0; out_ready toggled randomly → stream stays byte-exact against the reference model.
- reset asserted mid-COMMIT and mid-output-packet → next cycle: out_valid=0, pkts_ready=0, busy=0, and the next packet carries seq 0.
